hazard_interlock: RTL and testbench
===================================

# hazard_interlock

Interlock and stall generator for the 5-stage MIPS pipeline; the decision-side counterpart to operand forwarding. It sits beside the ID stage and keeps its own shadow copy of the destination registers in flight in EX, MEM and WB. From that copy it raises a stall whenever forwarding cannot satisfy the instruction in ID. It also counts stall cycles for performance monitoring.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `Valid_ID`  in  1  ID holds a real instruction (not a bubble).
- `Rs_ID`, `Rt_ID`  in  5  source register numbers in ID.
- `Use_Rs_ID`, `Use_Rt_ID`  in  1  the instruction actually reads Rs / Rt.
- `Rd_ID`  in  5  final destination register (after RegDst mux).
- `Reg_Write_ID`  in  1  the instruction writes the register file.
- `Mem_Read_ID`  in  1  the instruction is a load.
- `Flush`  in  1  taken branch or jump; the ID instruction is discarded this cycle.
- `Stall`  out  1  hold PC and IF/ID; combinational.
- `Bubble_EX`  out  1  load a NOP into ID/EX; equals `Stall | Flush`; combinational.
- `Stall_Count`  out  CNT_W  saturating count of cycles with `Stall` = 1.

## Operation
- Shadow pipeline with three registered slots:
  - EX slot: `ex_v`, `ex_rd`, `ex_ld`
  - MEM slot: `mem_v`, `mem_rd`, `mem_ld`
  - WB slot: `wb_v`, `wb_rd`
- The shadow advances every cycle; there is no global pipeline enable:
  - WB slot takes the MEM slot.
  - MEM slot takes the EX slot.
  - EX slot takes {1, `Rd_ID`, `Mem_Read_ID`} when `Valid_ID & Reg_Write_ID & (Rd_ID != 0) & !Stall & !Flush`. Otherwise the EX slot loads a bubble (valid = 0).
- Register $0 is never tracked, so it never causes a stall.
- Source match: `hit(slot)` = slot valid AND ((`Use_Rs_ID` AND `Rs_ID` == slot rd) OR (`Use_Rt_ID` AND `Rt_ID` == slot rd)).
- Stall rule in the default (forwarding) build: `Stall` = `Valid_ID & !Flush & ex_ld & hit(EX)`. This is the load-use case only; MEM and WB producers are forwarded.
- Priority: `Flush` overrides `Stall`. A flushed instruction never stalls.
- `Stall_Count` increments by 1 on every edge where `Stall` = 1. It holds at all-ones and does not wrap.

## Timing
- `Stall` and `Bubble_EX` are combinational from the ID inputs and the shadow state, with zero-cycle latency.
- Load-use hazard: `Stall` is high for exactly 1 cycle. On the next edge the load moves to the MEM slot and the EX slot holds a bubble, so `Stall` drops.
- Reset, asserted at any time including mid-stall:
  - all shadow valid bits clear immediately;
  - `Stall` = 0 and `Bubble_EX` = `Flush`;
  - `Stall_Count` = 0.
  - Nothing is replayed after reset.
- `Flush` and a hazard in the same cycle: `Stall` = 0, `Bubble_EX` = 1, and the EX slot loads a bubble.
- `Stall_Count` updates on the edge that ends the stalled cycle, so it is visible one cycle after `Stall` is high.

## Configuration
- `HAZ_FULL_INTERLOCK_EN` undefined (default): the load-use-only rule above, for cores with forwarding.
- `HAZ_FULL_INTERLOCK_EN` defined: for a core built without forwarding.
  - `Stall` = `Valid_ID & !Flush & (hit(EX) | hit(MEM) | hit(WB))`, ignoring `ex_ld`.
  - The register file has no write-through, so a WB match stalls too.
  - A dependent instruction directly behind its producer stalls for 3 cycles.

## Test plan
- Default build, `lw $8` followed immediately by `add $9,$8,$1` (Use_Rs=1): `Stall` = 1 and `Bubble_EX` = 1 for exactly one cycle, then 0. `Stall_Count` goes 0→1.
- Default build, `add $8` followed by `sub $9,$8,$8`: `Stall` stays 0 throughout (the dependency is left to forwarding).
- Load to `$0`, then a reader of `$0`; separately, a load to `$8` then an instruction with `Rt_ID`=8 and `Use_Rt_ID`=0: `Stall` stays 0 in both cases.
- Load-use hazard with `Flush`=1 in the same cycle: `Stall` = 0, `Bubble_EX` = 1, and the next cycle shows no stall. Also assert `rst` while `Stall` = 1: `Stall` drops immediately and `Stall_Count` = 0.
- Built with `HAZ_FULL_INTERLOCK_EN`: `add $8` followed by `add $9,$8,$2`: `Stall` high for 3 consecutive cycles and `Stall_Count` = 3. With the instruction three slots behind the producer, no stall.
- `CNT_W`=2, five separate load-use stalls: `Stall_Count` reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/hazard_interlock.sv
// ---------------------------------------------------------------------------
// hazard_interlock
//
// Interlock and stall generator for the 5-stage MIPS pipeline. It sits beside
// the ID stage and keeps a shadow copy of the destination registers that are
// in flight in EX, MEM and WB. It raises Stall whenever forwarding cannot
// satisfy the instruction in ID. It also keeps a saturating count of stalled
// cycles for performance monitoring.
//
// Configuration macro:
//   HAZ_FULL_INTERLOCK_EN  undefined (default): only a load in EX feeding the
//                          ID instruction stalls; MEM and WB producers are
//                          forwarded.
//                          defined: for a core without forwarding. Any
//                          EX/MEM/WB producer of a source register stalls.
//                          The register file has no write-through, so a WB
//                          match also stalls.
//
// Parameters:
//   CNT_W         width of the stall-cycle counter
//
// Ports:
//   clk           pipeline clock; all state updates on the rising edge
//   rst           asynchronous, active-high reset
//   Valid_ID      ID holds a real instruction (not a bubble)
//   Rs_ID, Rt_ID  source register numbers in ID
//   Use_Rs_ID     the ID instruction actually reads Rs
//   Use_Rt_ID     the ID instruction actually reads Rt
//   Rd_ID         final destination register (after the RegDst mux)
//   Reg_Write_ID  the ID instruction writes the register file
//   Mem_Read_ID   the ID instruction is a load
//   Flush         taken branch/jump; the ID instruction is discarded
//   Stall         hold PC and IF/ID (combinational)
//   Bubble_EX     load a NOP into ID/EX; Stall | Flush (combinational)
//   Stall_Count   saturating count of cycles with Stall = 1
// ---------------------------------------------------------------------------
module hazard_interlock #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Valid_ID,
  input  logic [4:0]       Rs_ID,
  input  logic [4:0]       Rt_ID,
  input  logic             Use_Rs_ID,
  input  logic             Use_Rt_ID,
  input  logic [4:0]       Rd_ID,
  input  logic             Reg_Write_ID,
  input  logic             Mem_Read_ID,
  input  logic             Flush,
  output logic             Stall,
  output logic             Bubble_EX,
  output logic [CNT_W-1:0] Stall_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [4:0]       REG_ZERO = 5'd0;

  // True when a valid shadow slot produces a register that ID actually reads.
  function automatic logic slot_hit(
    input logic       slot_v,
    input logic [4:0] slot_rd,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       use_rs,
    input logic       use_rt
  );
    slot_hit = slot_v & ((use_rs & (rs == slot_rd)) | (use_rt & (rt == slot_rd)));
  endfunction

  // Shadow slots. Register $0 is never loaded into a slot, so it can never
  // match and never causes a stall.
  logic             ex_v_r;
  logic [4:0]       ex_rd_r;
  logic             ex_ld_r;
  logic             mem_v_r;
  logic [4:0]       mem_rd_r;
  logic             mem_ld_r;
  logic             wb_v_r;
  logic [4:0]       wb_rd_r;
  logic [CNT_W-1:0] stall_count_r;

  logic             hit_ex_s;
  logic             hit_mem_s;
  logic             hit_wb_s;
  logic             stall_s;
  logic             issue_s;
  logic             ex_v_nxt_s;
  logic [4:0]       ex_rd_nxt_s;
  logic             ex_ld_nxt_s;
  logic [CNT_W-1:0] stall_count_nxt_s;

  // Slot fields that only some builds consult; kept for a uniform shadow.
  logic             unused_slot_bits_s;

  assign hit_ex_s  = slot_hit(ex_v_r,  ex_rd_r,  Rs_ID, Rt_ID, Use_Rs_ID, Use_Rt_ID);
  assign hit_mem_s = slot_hit(mem_v_r, mem_rd_r, Rs_ID, Rt_ID, Use_Rs_ID, Use_Rt_ID);
  assign hit_wb_s  = slot_hit(wb_v_r,  wb_rd_r,  Rs_ID, Rt_ID, Use_Rs_ID, Use_Rt_ID);

  assign unused_slot_bits_s = &{1'b0, mem_ld_r, hit_mem_s, hit_wb_s};

  // Stall decision; a flushed or bubble ID instruction never stalls.
  always_comb begin
    stall_s = 1'b0;
    if (Valid_ID && !Flush) begin
`ifdef HAZ_FULL_INTERLOCK_EN
      stall_s = hit_ex_s | hit_mem_s | hit_wb_s;
`else
      stall_s = ex_ld_r & hit_ex_s;
`endif
    end else begin
      stall_s = 1'b0;
    end
  end

  // An instruction enters the EX shadow only if it really proceeds and writes
  // a non-zero register.
  assign issue_s = Valid_ID & Reg_Write_ID & (Rd_ID != REG_ZERO) & ~stall_s & ~Flush;

  // Next EX slot contents: the issuing instruction, otherwise a bubble.
  always_comb begin
    ex_v_nxt_s  = 1'b0;
    ex_rd_nxt_s = REG_ZERO;
    ex_ld_nxt_s = 1'b0;
    if (issue_s) begin
      ex_v_nxt_s  = 1'b1;
      ex_rd_nxt_s = Rd_ID;
      ex_ld_nxt_s = Mem_Read_ID;
    end else begin
      ex_v_nxt_s  = 1'b0;
      ex_rd_nxt_s = REG_ZERO;
      ex_ld_nxt_s = 1'b0;
    end
  end

  // Next stall-counter value: increment on a stalled cycle, hold at all-ones.
  always_comb begin
    stall_count_nxt_s = stall_count_r;
    if (stall_s && (stall_count_r != CNT_MAX)) begin
      stall_count_nxt_s = stall_count_r + CNT_ONE;
    end else begin
      stall_count_nxt_s = stall_count_r;
    end
  end

  // Shadow pipeline: advances every cycle, no enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v_r   <= 1'b0;
      ex_rd_r  <= REG_ZERO;
      ex_ld_r  <= 1'b0;
      mem_v_r  <= 1'b0;
      mem_rd_r <= REG_ZERO;
      mem_ld_r <= 1'b0;
      wb_v_r   <= 1'b0;
      wb_rd_r  <= REG_ZERO;
    end else begin
      ex_v_r   <= ex_v_nxt_s;
      ex_rd_r  <= ex_rd_nxt_s;
      ex_ld_r  <= ex_ld_nxt_s;
      mem_v_r  <= ex_v_r;
      mem_rd_r <= ex_rd_r;
      mem_ld_r <= ex_ld_r;
      wb_v_r   <= mem_v_r;
      wb_rd_r  <= mem_rd_r;
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_r <= CNT_ZERO;
    end else begin
      stall_count_r <= stall_count_nxt_s;
    end
  end

  // Stall and Bubble_EX stay combinational so the hold takes effect in the
  // same cycle as the hazard; during reset the cleared shadow forces Stall low.
  assign Stall       = stall_s;
  assign Bubble_EX   = stall_s | Flush;
  assign Stall_Count = stall_count_r;

endmodule

// File: tb/tb_hazard_interlock.sv
// Self-checking bench for hazard_interlock. Two instances share all inputs:
// one with the default counter width, one with CNT_W = 2 for saturation.
// The reference model keeps a queue of issued producers tagged with their
// issue cycle; a producer's distance from ID is just the cycle difference.
module tb_hazard_interlock;

`ifdef HAZ_FULL_INTERLOCK_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
  } instr_t;

  typedef struct {
    int         c;
    logic [4:0] rd;
    logic       ld;
  } prod_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Valid_ID = 1'b0;
  logic [4:0]  Rs_ID = 5'd0;
  logic [4:0]  Rt_ID = 5'd0;
  logic        Use_Rs_ID = 1'b0;
  logic        Use_Rt_ID = 1'b0;
  logic [4:0]  Rd_ID = 5'd0;
  logic        Reg_Write_ID = 1'b0;
  logic        Mem_Read_ID = 1'b0;
  logic        Flush = 1'b0;
  logic        Stall, Bubble_EX, Stall_w2, Bubble_EX_w2;
  logic [15:0] Stall_Count;
  logic [1:0]  Stall_Count_w2;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  prod_t       hist[$];
  logic [15:0] cnt_exp = 16'd0;
  logic [1:0]  cnt2_exp = 2'd0;

  always #5 clk = ~clk;

  hazard_interlock u_dut (
    .clk(clk), .rst(rst), .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Use_Rs_ID(Use_Rs_ID), .Use_Rt_ID(Use_Rt_ID), .Rd_ID(Rd_ID),
    .Reg_Write_ID(Reg_Write_ID), .Mem_Read_ID(Mem_Read_ID), .Flush(Flush),
    .Stall(Stall), .Bubble_EX(Bubble_EX), .Stall_Count(Stall_Count)
  );

  hazard_interlock #(.CNT_W(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .Use_Rs_ID(Use_Rs_ID), .Use_Rt_ID(Use_Rt_ID), .Rd_ID(Rd_ID),
    .Reg_Write_ID(Reg_Write_ID), .Mem_Read_ID(Mem_Read_ID), .Flush(Flush),
    .Stall(Stall_w2), .Bubble_EX(Bubble_EX_w2), .Stall_Count(Stall_Count_w2)
  );

  function automatic instr_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urs, input logic urt, input logic [4:0] rd,
                                input logic rw, input logic ld);
    instr_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.rd = rd; i.rw = rw; i.ld = ld;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endfunction

  // lw $rd, off($rs)
  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs);
    return mk(1'b1, rs, rd, 1'b1, 1'b0, rd, 1'b1, 1'b1);
  endfunction

  // R-type: op $rd, $rs, $rt
  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0);
  endfunction

  // Spec rule: a producer issued d cycles ago sits in EX (d=1), MEM (2), WB (3).
  function automatic logic model_stall(input instr_t ins, input logic fl);
    logic s = 1'b0;
    if (ins.v && !fl) begin
      foreach (hist[k]) begin
        int  d = cyc - hist[k].c;
        logic h = (ins.urs && ins.rs == hist[k].rd) || (ins.urt && ins.rt == hist[k].rd);
        if (FULL) begin
          if (h && d >= 1 && d <= 3) s = 1'b1;
        end else begin
          if (h && d == 1 && hist[k].ld) s = 1'b1;
        end
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    hist.delete();
    cnt_exp  = 16'd0;
    cnt2_exp = 2'd0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One pipeline cycle: drive at negedge, check mid-cycle, update model at posedge.
  // want_stall / want_w2 >= 0 add a directed expectation on top of the model.
  task automatic step(input instr_t ins, input logic fl, input logic r,
                      input int want_stall, input int want_w2);
    logic s_exp;
    @(negedge clk);
    Valid_ID = ins.v; Rs_ID = ins.rs; Rt_ID = ins.rt;
    Use_Rs_ID = ins.urs; Use_Rt_ID = ins.urt; Rd_ID = ins.rd;
    Reg_Write_ID = ins.rw; Mem_Read_ID = ins.ld; Flush = fl; rst = r;
    #1;
    if (r) model_reset();
    s_exp = model_stall(ins, fl);
    chk("stall", 32'(Stall), 32'(s_exp));
    chk("bubble_ex", 32'(Bubble_EX), 32'(s_exp | fl));
    chk("stall_count", 32'(Stall_Count), 32'(cnt_exp));
    chk("stall_w2", 32'(Stall_w2), 32'(s_exp));
    chk("stall_count_w2", 32'(Stall_Count_w2), 32'(cnt2_exp));
    if (want_stall >= 0) chk("plan_stall", 32'(Stall), 32'(want_stall));
    if (want_w2 >= 0) chk("plan_count_w2", 32'(Stall_Count_w2), 32'(want_w2));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (s_exp) begin
        if (cnt_exp != 16'hFFFF) cnt_exp = cnt_exp + 16'd1;
        if (cnt2_exp != 2'd3) cnt2_exp = cnt2_exp + 2'd1;
      end
      if (ins.v && ins.rw && ins.rd != 5'd0 && !s_exp && !fl)
        hist.push_back('{cyc, ins.rd, ins.ld});
    end
    cyc++;
    while (hist.size() > 0 && (cyc - hist[0].c) > 3) hist.pop_front();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(nop(), 1'b0, 1'b0, -1, -1);
  endtask

  initial begin
    instr_t ri;
    logic   rfl, rrs;

    // Reset state
    step(nop(), 1'b0, 1'b1, 0, 0);
    step(nop(), 1'b1, 1'b1, 0, 0);
    idle(2);

    // lw $8 ; add $9,$8,$1 : one stall cycle, count 0 -> 1
    step(lw(5'd8, 5'd1), 1'b0, 1'b0, 0, 0);
    step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, 1, 0);
    step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, FULL ? -1 : 0, 1);
    idle(4);

    // add $8 ; sub $9,$8,$8 : forwarded in the default build
    step(alu(5'd8, 5'd1, 5'd2), 1'b0, 1'b0, 0, -1);
    step(alu(5'd9, 5'd8, 5'd8), 1'b0, 1'b0, FULL ? 1 : 0, -1);
    idle(4);

    // Load to $0 then a reader of $0; load to $8 then Rt=8 with Use_Rt=0
    step(lw(5'd0, 5'd1), 1'b0, 1'b0, 0, -1);
    step(alu(5'd9, 5'd0, 5'd0), 1'b0, 1'b0, 0, -1);
    idle(4);
    step(lw(5'd8, 5'd1), 1'b0, 1'b0, 0, -1);
    step(mk(1'b1, 5'd3, 5'd8, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0), 1'b0, 1'b0, 0, -1);
    idle(4);

    // Load-use with Flush in the same cycle
    step(lw(5'd8, 5'd1), 1'b0, 1'b0, 0, -1);
    step(alu(5'd9, 5'd8, 5'd1), 1'b1, 1'b0, 0, -1);
    step(alu(5'd10, 5'd8, 5'd1), 1'b0, 1'b0, FULL ? -1 : 0, -1);
    idle(4);

    // Reset asserted while stalled
    step(lw(5'd8, 5'd1), 1'b0, 1'b0, 0, -1);
    step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, 1, -1);
    step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b1, 0, 0);
    step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, 0, 0);
    idle(4);

    // Dependent ALU op directly behind its producer (3 stalls in full build)
    step(nop(), 1'b0, 1'b1, 0, 0);
    step(alu(5'd8, 5'd1, 5'd1), 1'b0, 1'b0, 0, 0);
    for (int k = 0; k < 3; k++) step(alu(5'd9, 5'd8, 5'd2), 1'b0, 1'b0, FULL ? 1 : 0, -1);
    step(alu(5'd9, 5'd8, 5'd2), 1'b0, 1'b0, 0, FULL ? 3 : 0);
    idle(4);

    // Reader three slots behind its producer
    step(alu(5'd8, 5'd1, 5'd1), 1'b0, 1'b0, 0, -1);
    idle(3);
    step(alu(5'd9, 5'd8, 5'd2), 1'b0, 1'b0, 0, -1);
    idle(4);

    // Five separate load-use stalls: 2-bit counter reads 1,2,3,3,3
    step(nop(), 1'b0, 1'b1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(lw(5'd8, 5'd1), 1'b0, 1'b0, 0, -1);
      step(alu(5'd9, 5'd8, 5'd1), 1'b0, 1'b0, 1, -1);
      step(nop(), 1'b0, 1'b0, 0, (k + 1 > 3) ? 3 : k + 1);
      idle(3);
    end

    // Randomized traffic on a small register set to provoke hazards
    for (int k = 0; k < 600; k++) begin
      ri.v   = ($urandom_range(0, 7) != 0);
      ri.rs  = 5'($urandom_range(0, 3));
      ri.rt  = 5'($urandom_range(0, 3));
      ri.urs = 1'($urandom_range(0, 1));
      ri.urt = 1'($urandom_range(0, 1));
      ri.rd  = 5'($urandom_range(0, 3));
      ri.rw  = ($urandom_range(0, 3) != 0);
      ri.ld  = ri.rw & 1'($urandom_range(0, 1));
      rfl    = ($urandom_range(0, 7) == 0);
      rrs    = ($urandom_range(0, 63) == 0);
      step(ri, rfl, rrs, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
